// File: rtl/cordic_nco_frontend.sv
// Phase-accumulator front end for a pipelined CORDIC sine/cosine stage: issues
// angle/x/y samples for burst or continuous runs and tracks their validity through the pipe.
module cordic_nco_frontend #(
    parameter int               WIDTH   = 32,
    parameter int               LATENCY = 32,
    parameter logic [WIDTH-1:0] AMP     = 'h4DBA76D4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_ftw,
    input  logic [31:0]      cfg_phase,
    input  logic [15:0]      cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic [31:0]      angle,
    output logic [WIDTH-1:0] x_start,
    output logic [WIDTH-1:0] y_start,
    output logic             cordic_in_valid,
    output logic             cordic_out_valid,
    output logic             busy,
    output logic             done
);

    localparam int DCW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LATENCY - 1);
    localparam logic [DCW-1:0] DONE_AT    = DCW'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        ftw_q, ftw_d;
    logic [31:0]        phase_q, phase_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        remaining_q, remaining_d;
    logic [DCW-1:0]     drain_q, drain_d;
    logic [LATENCY-1:0] vsr_q, vsr_d;
    logic               in_valid_q, in_valid_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic               busy_q, busy_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               done_q, done_d;
    logic               cfg_take;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ftw_d       = ftw_q;
        phase_d     = phase_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        done_d      = 1'b0;
        cfg_take    = cfg_valid && (state_q == S_IDLE);

        if (cfg_take) begin
            ftw_d   = cfg_ftw;
            phase_d = cfg_phase;
            count_d = cfg_count;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A config word arriving with start must govern this very run.
                    state_d     = S_RUN;
                    acc_d       = cfg_take ? cfg_phase : phase_q;
                    remaining_d = cfg_take ? cfg_count : count_q;
                end
            end
            S_RUN: begin
                acc_d = acc_q + ftw_q;
                if (count_q != 16'd0) begin
                    remaining_d = remaining_q - 16'd1;
                end
                if (stop || ((count_q != 16'd0) && (remaining_q == 16'd1))) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                // done lands in the cycle the final sample reaches cordic_out_valid.
                if (drain_q == DONE_AT) begin
                    done_d = 1'b1;
                end
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_valid_d  = (state_d == S_RUN);
        x_d         = in_valid_d ? AMP : '0;
        busy_d      = (state_d != S_IDLE);
        cfg_ready_d = (state_d == S_IDLE);
    end

    assign vsr_d[0] = in_valid_q;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vsr
            assign vsr_d[gi] = vsr_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            ftw_q       <= '0;
            phase_q     <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            drain_q     <= '0;
            vsr_q       <= '0;
            in_valid_q  <= 1'b0;
            x_q         <= '0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ftw_q       <= ftw_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            vsr_q       <= vsr_d;
            in_valid_q  <= in_valid_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
            done_q      <= done_d;
        end
    end

    assign angle            = acc_q;
    assign x_start          = x_q;
    assign y_start          = '0;
    assign cordic_in_valid  = in_valid_q;
    assign cordic_out_valid = vsr_q[LATENCY-1];
    assign busy             = busy_q;
    assign cfg_ready        = cfg_ready_q;
    assign done             = done_q;

endmodule

// File: tb/tb_cordic_nco_frontend.sv
// Scoreboard bench: stimulus queues expected angles/sines, a negedge monitor checks every
// issued sample, the out_valid alignment, the done pulse and a reference CORDIC result.
module tb_cordic_nco_frontend;

    localparam int          L   = 32;
    localparam logic [31:0] AMP = 32'h4DBA76D4;
    localparam real         PI  = 3.141592653589793;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_ftw = '0;
    logic [31:0] cfg_phase = '0;
    logic [15:0] cfg_count = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] angle;
    logic [31:0] x_start;
    logic [31:0] y_start;
    logic        cordic_in_valid;
    logic        cordic_out_valid;
    logic        busy;
    logic        done;

    cordic_nco_frontend #(.WIDTH(32), .LATENCY(L), .AMP(AMP)) dut (
        .clock(clock), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_count(cfg_count),
        .start(start), .stop(stop),
        .angle(angle), .x_start(x_start), .y_start(y_start),
        .cordic_in_valid(cordic_in_valid), .cordic_out_valid(cordic_out_valid),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int n_in = 0;
    int n_out = 0;
    int done_cyc = 0;
    int last_in_cyc = 0;
    int run_in0, run_out0;
    bit t6 = 1'b0;

    logic [31:0] exp_angle_q[$];
    int          inflight_q[$];
    longint      cord_s_q[$], cord_c_q[$], exp_s_q[$], exp_c_q[$];
    logic [31:0] atan_tab[31];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
        longint diff;
        diff = act - exp;
        n_vec++;
        if (diff > tol || diff < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Reference rotation-mode CORDIC, 31 micro-rotations, angle in 2^32-per-turn units.
    function automatic void cordic_ref(input logic [31:0] ang, input logic [31:0] x0,
                                       output longint c, output longint s);
        longint x, y, xn;
        logic [31:0] z;
        x = longint'(x0);
        y = 0;
        z = ang;
        if (z[31] ^ z[30]) begin
            x = -x;
            z = z + 32'h8000_0000;
        end
        for (int i = 0; i < 31; i++) begin
            if (!z[31]) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - atan_tab[i];
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + atan_tab[i];
            end
            x = xn;
        end
        c = x;
        s = y;
    endfunction

    always @(negedge clock) begin : monitor
        longint c_v, s_v;
        int     t_in;
        if (!reset_n) begin
            inflight_q.delete();
            cord_s_q.delete();
            cord_c_q.delete();
        end else begin
            check("y_start", y_start, 0);
            if (cordic_in_valid) begin
                n_in++;
                last_in_cyc = cyc;
                inflight_q.push_back(cyc);
                if (exp_angle_q.size() > 0) check("angle", angle, exp_angle_q.pop_front());
                check("x_start_run", x_start, AMP);
                if (t6) begin
                    cordic_ref(angle, x_start, c_v, s_v);
                    cord_c_q.push_back(c_v);
                    cord_s_q.push_back(s_v);
                end
            end else begin
                check("x_start_idle", x_start, 0);
            end
            if (cordic_out_valid) begin
                n_out++;
                check("out_valid_has_sample", inflight_q.size() > 0, 1);
                if (inflight_q.size() > 0) begin
                    t_in = inflight_q.pop_front();
                    check("out_valid_latency", cyc - t_in, L);
                end
                if (t6 && cord_s_q.size() > 0 && exp_s_q.size() > 0) begin
                    check_tol("t6_sin", cord_s_q.pop_front(), exp_s_q.pop_front(), 64);
                    check_tol("t6_cos", cord_c_q.pop_front(), exp_c_q.pop_front(), 64);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_before_last_out", inflight_q.size(), 0);
                check("done_latency", cyc - last_in_cyc, L);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_angle"}, angle, 0);
        check({tag, "_x"}, x_start, 0);
        check({tag, "_y"}, y_start, 0);
        check({tag, "_in_valid"}, cordic_in_valid, 0);
        check({tag, "_out_valid"}, cordic_out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_ready"}, cfg_ready, 1);
    endtask

    task automatic do_cfg(input logic [31:0] ftw, input logic [31:0] ph, input logic [15:0] cnt);
        cfg_valid = 1'b1; cfg_ftw = ftw; cfg_phase = ph; cfg_count = cnt;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic launch(input bit with_cfg, input logic [31:0] ftw, input logic [31:0] ph,
                          input logic [15:0] cnt);
        run_in0  = n_in;
        run_out0 = n_out;
        cfg_valid = with_cfg; cfg_ftw = ftw; cfg_phase = ph; cfg_count = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic finish_run(input string name, input int n_exp);
        int base;
        base = done_cnt - (done && reset_n ? 1 : 0);
        for (int i = 0; i < 400 && done_cnt == base; i++) tick();
        check({name, "_done_seen"}, done_cnt, base + 1);
        repeat (5) tick();
        check({name, "_single_done"}, done_cnt, base + 1);
        check({name, "_in_count"}, n_in - run_in0, n_exp);
        check({name, "_out_count"}, n_out - run_out0, n_exp);
        check({name, "_angles_left"}, exp_angle_q.size(), 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_cfg_ready"}, cfg_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int stop_cyc, done0, out0;
        for (int i = 0; i < 31; i++)
            atan_tab[i] = 32'(longint'($atan(1.0 / (2.0 ** i)) / (2.0 * PI) * 4294967296.0));

        repeat (3) tick();
        check_reset_outputs("por");
        reset_n = 1'b1;
        tick();

        // T1: reset in the middle of a continuous run
        do_cfg(32'h0000_0100, 32'h0, 16'd0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        check("t1_running", cordic_in_valid, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("t1_hold");
        repeat (3) tick();
        check_reset_outputs("t1_hold2");
        reset_n = 1'b1;
        done0 = done_cnt;
        out0  = n_out;
        repeat (L + 10) tick();
        check("t1_no_done", done_cnt, done0);
        check("t1_no_out_valid", n_out, out0);
        check("t1_idle", busy, 0);

        // T2: 4-sample burst
        do_cfg(32'h0100_0000, 32'h0, 16'd4);
        exp_angle_q = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000};
        launch(1'b0, '0, '0, '0);
        finish_run("t2", 4);

        // T3: phase wrap, config together with start
        exp_angle_q = '{32'hFF00_0000, 32'hFF80_0000, 32'h0000_0000};
        launch(1'b1, 32'h0080_0000, 32'hFF00_0000, 16'd3);
        finish_run("t3", 3);

        // T4: continuous run, stop after 100 cycles
        for (int n = 0; n <= 100; n++) exp_angle_q.push_back(32'd5 + 32'(n) * 32'h10);
        launch(1'b1, 32'h10, 32'd5, 16'd0);
        repeat (100) tick();
        stop = 1'b1;
        stop_cyc = cyc;
        tick();
        stop = 1'b0;
        finish_run("t4", 101);
        check("t4_done_after_stop", done_cyc - stop_cyc, L);

        // T5: same-cycle cfg+start wins over the old config; RUN ignores cfg/start
        do_cfg(32'h1, 32'h0, 16'd3);
        exp_angle_q = '{32'h10, 32'h12, 32'h14};
        launch(1'b1, 32'h2, 32'h10, 16'd3);
        cfg_valid = 1'b1; start = 1'b1;
        cfg_ftw = 32'h7; cfg_phase = 32'h999; cfg_count = 16'd9;
        check("t5_cfg_ready_run", cfg_ready, 0);
        check("t5_busy_run", busy, 1);
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        finish_run("t5a", 3);
        exp_angle_q = '{32'h10, 32'h12, 32'h14};
        launch(1'b0, '0, '0, '0);
        finish_run("t5b", 3);

        // T6: 64-point sine/cosine through a reference CORDIC
        for (int n = 0; n < 64; n++) begin
            exp_angle_q.push_back(32'(n) * 32'h0400_0000);
            exp_s_q.push_back(longint'(2147483648.0 * $sin(2.0 * PI * n / 64.0)));
            exp_c_q.push_back(longint'(2147483648.0 * $cos(2.0 * PI * n / 64.0)));
        end
        t6 = 1'b1;
        launch(1'b1, 32'h0400_0000, 32'h0, 16'd64);
        finish_run("t6", 64);
        t6 = 1'b0;
        check("t6_sines_left", exp_s_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
